// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state and owner encodings shared by the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2,
    ARB_ACK  = 2'd3
  } arb_state_t;
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_DM   = 2'd2
  } owner_t;
  localparam int BURST_W = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store with a starvation guard
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic [3:0]        dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_DATA_BURST);
  arb_state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic mem_req_q, mem_req_d, if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
  logic [3:0] mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic fetch, rsp;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  // next state, arbitration, payload latch and response capture
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_d     = burst_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    fetch       = if_req && (!dm_req || burst_q == MAX_B);
    rsp         = 1'b0;
    case (state_q)
      ARB_IDLE: if (if_req || dm_req) begin
        owner_d     = fetch ? OWNER_IF : OWNER_DM;
        mem_req_d   = 1'b1;
        mem_addr_d  = fetch ? if_addr : dm_addr;
        mem_we_d    = fetch ? 4'd0 : dm_we;
        mem_wdata_d = fetch ? '0 : dm_wdata;
        burst_d     = (fetch || !if_req) ? '0 : (burst_q == MAX_B ? burst_q : burst_q + 1'b1);
        state_d     = ARB_REQ;
      end
      ARB_REQ: if (mem_gnt) begin
        mem_req_d = 1'b0;
        rsp       = mem_rvalid;
        state_d   = mem_rvalid ? ARB_ACK : ARB_RSP;
      end
      ARB_RSP: begin
        rsp     = mem_rvalid;
        state_d = mem_rvalid ? ARB_ACK : ARB_RSP;
      end
      default: begin
        owner_d = OWNER_NONE;
        state_d = ARB_IDLE;
      end
    endcase
    if (rsp) begin
      if_ack_d   = owner_q == OWNER_IF;
      dm_ack_d   = owner_q == OWNER_DM;
      if_rdata_d = owner_q == OWNER_IF ? mem_rdata : if_rdata_q;
      dm_rdata_d = (owner_q == OWNER_DM && mem_we_q == 4'd0) ? mem_rdata : dm_rdata_q;
    end
  end
  // state and registered outputs; reset aborts any in-flight transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_NONE;
      burst_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end
`ifndef SYNTHESIS
  // warn about memory handshakes arriving when no transaction can take them
  always @(posedge clk) begin
    if (rst_n && mem_gnt && state_q != ARB_REQ)
      $display("mem_arbiter warning: mem_gnt outside REQ ignored at %0t", $time);
    if (rst_n && mem_rvalid && state_q != ARB_REQ && state_q != ARB_RSP)
      $display("mem_arbiter warning: mem_rvalid outside REQ/RSP ignored at %0t", $time);
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for the memory arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic [3:0]  dm_we = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // grant in REQ, answer one cycle later; returns with the ack visible
  task automatic serve(input logic [31:0] data);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = data;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b we=%h addr=%h wd=%h ia=%b da=%b ir=%h dr=%h want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_no_req: got %b want 0", mem_req); end
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1;
    if_addr = 32'h0000_0040;
    tick();
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 4'h0, 32'h40}) begin
      bad++; $display("FAIL fetch_req: got req=%b we=%h addr=%h want 1 0 00000040", mem_req, mem_we, mem_addr);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    total++;
    if ({mem_req, if_ack} !== 2'b00) begin
      bad++; $display("FAIL fetch_granted: got req=%b ack=%b want 0 0", mem_req, if_ack);
    end
    mem_rvalid = 1'b1;
    mem_rdata = 32'h2010_FFFF;
    tick();
    mem_rvalid = 1'b0;
    total++;
    if ({if_ack, dm_ack, if_rdata} !== {2'b10, 32'h2010_FFFF}) begin
      bad++; $display("FAIL fetch_ack: got ia=%b da=%b rd=%h want 1 0 2010ffff", if_ack, dm_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
    total++;
    if ({if_ack, if_rdata} !== {1'b0, 32'h2010_FFFF}) begin
      bad++; $display("FAIL fetch_ack_once: got ia=%b rd=%h want 0 2010ffff", if_ack, if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 4'hF; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    tick();
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL simul_store_first: got req=%b we=%h addr=%h wd=%h want 1 f 00000100 deadbeef",
                      mem_req, mem_we, mem_addr, mem_wdata);
    end
    serve(32'h1234_5678);
    total++;
    if ({dm_ack, if_ack, dm_rdata} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL simul_store_ack: got da=%b ia=%b dr=%h want 1 0 00000000", dm_ack, if_ack, dm_rdata);
    end
    dm_req = 1'b0;
    tick();
    total++;
    if ({mem_req, dm_ack} !== 2'b00) begin
      bad++; $display("FAIL simul_ack_no_sample: got req=%b da=%b want 0 0", mem_req, dm_ack);
    end
    tick();
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'h0, 32'h80, 32'h0}) begin
      bad++; $display("FAIL simul_fetch_second: got req=%b we=%h addr=%h wd=%h want 1 0 00000080 00000000",
                      mem_req, mem_we, mem_addr, mem_wdata);
    end
    serve(32'hCAFE_0001);
    total++;
    if ({if_ack, dm_ack, if_rdata} !== {2'b10, 32'hCAFE_0001}) begin
      bad++; $display("FAIL simul_fetch_ack: got ia=%b da=%b rd=%h want 1 0 cafe0001", if_ack, dm_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [9:0] seq_i;
    seq_i = 10'b10_0001_0000;
    if_req = 1'b1; if_addr = 32'h1000;
    dm_req = 1'b1; dm_we = 4'h0; dm_addr = 32'h200; dm_wdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({mem_req, mem_addr} !== {1'b1, seq_i[i] ? if_addr : dm_addr}) begin
        bad++; $display("FAIL burst_grant_%0d: got req=%b addr=%h want 1 %h", i, mem_req, mem_addr,
                        seq_i[i] ? if_addr : dm_addr);
      end
      serve(32'hA000_0000 + i);
      total++;
      if ({if_ack, dm_ack, seq_i[i] ? if_rdata : dm_rdata} !== {seq_i[i], ~seq_i[i], 32'hA000_0000 + i}) begin
        bad++; $display("FAIL burst_ack_%0d: got ia=%b da=%b rd=%h want %b %b %h", i, if_ack, dm_ack,
                        seq_i[i] ? if_rdata : dm_rdata, seq_i[i], ~seq_i[i], 32'hA000_0000 + i);
      end
      if (seq_i[i]) if_addr = if_addr + 32'h4;
      else dm_addr = dm_addr + 32'h4;
      tick();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  task automatic test_delayed_grant();
    dm_req = 1'b1; dm_we = 4'b0011; dm_addr = 32'h300; dm_wdata = 32'h55AA_55AA;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, dm_ack} !== {1'b1, 4'b0011, 32'h300, 32'h55AA_55AA, 1'b0}) begin
        bad++; $display("FAIL hold_%0d: got req=%b we=%h addr=%h wd=%h da=%b want 1 3 00000300 55aa55aa 0",
                        i, mem_req, mem_we, mem_addr, mem_wdata, dm_ack);
      end
    end
    serve(32'hFFFF_0000);
    total++;
    if ({dm_ack, dm_rdata} !== {1'b1, 32'hA000_0008}) begin
      bad++; $display("FAIL delayed_ack: got da=%b dr=%h want 1 a0000008", dm_ack, dm_rdata);
    end
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    if_req = 1'b1; if_addr = 32'h500;
    tick();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    total++;
    if ({if_ack, mem_req, if_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL same_cycle_ack: got ia=%b req=%b rd=%h want 1 0 0badf00d", if_ack, mem_req, if_rdata);
    end
    if_req = 1'b0;
    tick();
    total++;
    if (if_ack !== 1'b0) begin bad++; $display("FAIL same_cycle_once: got %b want 0", if_ack); end
  endtask

  task automatic test_reset_in_rsp();
    dm_req = 1'b1; dm_we = 4'h0; dm_addr = 32'h600;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    dm_req = 1'b0;
    tick();
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata} !== '0) begin
      bad++; $display("FAIL rsp_reset_outputs: got req=%b addr=%h ia=%b da=%b ir=%h dr=%h want all 0",
                      mem_req, mem_addr, if_ack, dm_ack, if_rdata, dm_rdata);
    end
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_rvalid = 1'b0;
    total++;
    if ({dm_ack, if_ack, mem_req, dm_rdata} !== {3'b000, 32'h0}) begin
      bad++; $display("FAIL late_rvalid: got da=%b ia=%b req=%b dr=%h want 0 0 0 00000000",
                      dm_ack, if_ack, mem_req, dm_rdata);
    end
    if_req = 1'b1; if_addr = 32'h700;
    tick();
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin
      bad++; $display("FAIL post_reset_req: got req=%b addr=%h want 1 00000700", mem_req, mem_addr);
    end
    serve(32'h0700_DA7A);
    total++;
    if ({if_ack, if_rdata} !== {1'b1, 32'h0700_DA7A}) begin
      bad++; $display("FAIL post_reset_ack: got ia=%b rd=%h want 1 0700da7a", if_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_delayed_grant();
    test_same_cycle();
    test_reset_in_rsp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
